// File: rtl/dcache_controller.sv
// Data-cache controller for a 2-way, 16-set, 32-byte-line SRAM.
// Serves load/store hits in one cycle. On a miss it writes back a dirty
// victim, refills the line, and then replays the request as a hit.
module dcache_controller #(
    parameter int MEM_ADDR_W = 32,
    parameter int LINE_W     = 256,
    parameter int TAG_W      = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    output logic [3:0]            sram_index_o,
    output logic [TAG_W+1:0]      sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    input  logic [TAG_W+1:0]      sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, REFILL} state_t;

    state_t             state, next_state;
    logic               pulse_q;        // first cycle of a memory transaction
    logic [LINE_W-1:0]  line_q;         // victim line, then refill line
    logic [TAG_W-1:0]   victim_tag_q;

    logic [TAG_W-1:0]   tag;
    logic [3:0]         index;
    logic [7:0]         bit_off;
    logic [LINE_W-1:0]  merged;

    assign tag     = cpu_addr_i[MEM_ADDR_W-1:9];
    assign index   = cpu_addr_i[8:5];
    assign bit_off = {cpu_addr_i[4:2], 5'b0};

    // Byte offset within a word is irrelevant to word-granular accesses.
    wire unused_addr_bits = ^cpu_addr_i[1:0];

    // Store data merged into the hit line.
    always_comb begin
        merged = sram_data_i;
        merged[bit_off +: 32] = cpu_data_i;
    end

    // State, transaction-entry pulse and latched lines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            pulse_q      <= 1'b0;
            line_q       <= '0;
            victim_tag_q <= '0;
        end else begin
            state   <= next_state;
            pulse_q <= (next_state == WRITEBACK && state != WRITEBACK) ||
                       (next_state == READMISS  && state != READMISS);
            if (state == MISS) begin
                line_q       <= sram_data_i;
                victim_tag_q <= sram_tag_i[TAG_W-1:0];
            end else if (state == READMISS && mem_ack_i) begin
                line_q <= mem_data_i;
            end
        end
    end

    // Next state and all outputs; every output is forced low during reset.
    always_comb begin
        next_state    = state;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_index_o  = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        if (!rst_i) begin
            cpu_stall_o = cpu_req_i & ~(state == IDLE && sram_hit_i);
            if (cpu_req_i) begin
                sram_enable_o = 1'b1;
                sram_index_o  = index;
                sram_tag_o    = {1'b1, cpu_write_i, tag};
            end
            case (state)
                IDLE: begin
                    if (cpu_req_i && sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = {1'b1, 1'b1, tag};
                            sram_data_o  = merged;
                        end else begin
                            cpu_data_o = sram_data_i[bit_off +: 32];
                        end
                    end else if (cpu_req_i) begin
                        next_state = MISS;
                    end
                end
                MISS: begin
                    next_state = (sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W])
                                 ? WRITEBACK : READMISS;
                end
                WRITEBACK: begin
                    mem_enable_o = pulse_q;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {victim_tag_q, index, 5'b0};
                    mem_data_o   = line_q;
                    if (mem_ack_i) next_state = READMISS;
                end
                READMISS: begin
                    mem_enable_o = pulse_q;
                    mem_addr_o   = {tag, index, 5'b0};
                    if (mem_ack_i) next_state = REFILL;
                end
                REFILL: begin
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_index_o  = index;
                    sram_tag_o    = {1'b1, 1'b0, tag};
                    sram_data_o   = line_q;
                    next_state    = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule
